// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the single-gate BIST controller.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_VECTORS = 4;

  // Truth tables indexed by {a,b}: bit 0 is a=0,b=0 and bit 3 is a=1,b=1.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_bist.sv
// Applies all four {a,b} vectors to a 2-input gate, samples y after a settle
// time and compares the captured truth table against the expected one.
//
// state | meaning
// IDLE  | outputs parked at 0, waiting for start
// RUN   | vector idx driven on {a,b}, settle counter running
// DONE  | one-cycle done pulse, results valid
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] expected,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] observed,
  output logic [3:0] fail_mask
);

  localparam int             CW       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [1:0]     IDX_LAST = 2'(NUM_VECTORS - 1);

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    exp_q;
  logic          sample;
  logic          last;
  logic [3:0]    obs_next;

  // State register; reset aborts any run straight back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, gate stimulus and the sample strobe for the current vector.
  always_comb begin
    state_next = state;
    a          = 1'b0;
    b          = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    sample     = 1'b0;
    last       = 1'b0;
    obs_next   = observed;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        {a, b} = idx;
        busy   = 1'b1;
        if (cnt == CNT_LAST) begin
          sample        = 1'b1;
          obs_next[idx] = y;
          if (idx == IDX_LAST) begin
            last       = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture expected at acceptance, collect samples, and register
  // the verdict from the final sample so it is valid during the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      exp_q     <= '0;
      observed  <= '0;
      fail_mask <= '0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            exp_q     <= expected;
            observed  <= '0;
            fail_mask <= '0;
            pass      <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
          end
        end
        RUN: begin
          if (sample) begin
            cnt      <= '0;
            observed <= obs_next;
            if (last) begin
              fail_mask <= obs_next ^ exp_q;
              pass      <= (obs_next == exp_q);
            end else begin
              idx <= idx + 2'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gate_bist.md
# gate_bist

Built-in self-test controller for a single 2-input logic gate. It sequences all four input combinations onto the gate under test and samples the gate's output after a programmable settle time. It compares the captured 4-bit truth table against an expected one and reports pass/fail with a per-vector mismatch mask. It sits beside the gate library as the synthesizable stimulus/response end of gate verification, so the same check runs in simulation and on hardware.

## Interface
- SETTLE_CYCLES, 2: cycles each vector is held before `y` is sampled; legal range ≥1, 0 is illegal.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level-sampled request; accepted only in IDLE.
- expected  in  4  expected truth table. Bit index is {a,b}, e.g. XOR = 4'b0110. Captured at start acceptance.
- y  in  1  output of the gate under test.
- a  out  1  stimulus to the gate under test.
- b  out  1  stimulus to the gate under test.
- busy  out  1  high while vectors are being applied.
- done  out  1  one-cycle pulse when results become valid.
- pass  out  1  1 when observed == captured expected; held until the next start is accepted.
- observed  out  4  captured truth table, bit {a,b} = sampled `y`.
- fail_mask  out  4  observed ^ expected; held with `pass`.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE**
  - a=b=0, busy=0.
  - On a clock edge with start=1: capture `expected`, clear observed/fail_mask/pass, set vector index=0 and settle count=0, go to RUN.
- **RUN**
  - {a,b} = index. busy=1. Count increments every cycle.
  - At the edge where count==SETTLE_CYCLES-1: write `y` into observed[index] and reset count to 0.
  - If index==3, go to DONE. Otherwise increment index; a/b update on that same edge.
- **DONE**
  - Lasts one cycle. done=1, busy=0, a=b=0.
  - fail_mask and pass are registered on entry, using the final sample.
  - Return to IDLE.
- `start` is ignored in RUN and DONE; it is not queued.
- Changes to `expected` after acceptance are ignored.
- `y` is sampled as-is; there is no synchronizer, and the gate under test is assumed to share the clock domain.
- Count width: $clog2(SETTLE_CYCLES+1). Index width: 2 bits; it never wraps within a run.

## Timing
- Reset value of every output is 0: a, b, busy, done, pass, observed, fail_mask.
- Reset takes effect immediately and can occur mid-run. It aborts the run without asserting done, and the state goes to IDLE.
- Let E0 be the edge that accepts start. Vector k is driven from after edge E0+k·S until edge E0+(k+1)·S, where S=SETTLE_CYCLES.
- `y` for vector k is sampled at edge E0+(k+1)·S.
- done is high in the cycle after edge E0+4·S.
- busy is high from after E0 through edge E0+4·S.
- Total start-to-done latency is 4·S+1 cycles. With S=2, done rises 9 edges after E0.
- start held high continuously causes back-to-back runs. Each new run begins at the first IDLE edge after DONE, giving one IDLE cycle between runs.

## Structure
- Shared package `gate_bist_pkg` holds:
  - State enum: IDLE, RUN, DONE.
  - NUM_VECTORS = 4.
  - Truth-table constants: TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XNOR=4'b1001.
- Single module. No sub-module is warranted; the settle counter stays inline.

## Test plan
- **Ideal XOR pass.** S=2, expected=TT_XOR, y=a^b combinational, pulse start. Required: done pulses 9 cycles after E0; observed=0110, fail_mask=0000, pass=1.
- **Wrong gate.** expected=TT_XOR, y=a&b. Required: observed=1000, fail_mask=1110, pass=0.
- **Stuck-at faults.** With y stuck at 1 and expected=0000: observed=1111, fail_mask=1111, pass=0. With y stuck at 0: pass=1.
- **Sequencing and ignored inputs.** Monitor {a,b}: it must read 00,01,10,11 with each value held exactly 2 cycles, then return to 00. Required: busy high for exactly 8 cycles; start pulses and `expected` changes during RUN have no effect.
- **Reset mid-run.** Assert rst while vector 2 is driven. Required: a=b=busy=done=pass=0 and observed=0000 immediately, with no done pulse. A following start completes normally with pass=1 for an ideal XOR.
- **Settle-time sensitivity.** y is XOR delayed one clock. With S=2: pass=1. With S=1: observed=1100, fail_mask=1010, pass=0.
